// File: rtl/key_debounce_scan.sv
// key_debounce_scan: synchronises, debounces and encodes the raw key pins.
// Ports:
//   clk         system clock, sole clock
//   reset       asynchronous active-high reset
//   key_raw     raw bouncing key pins (polarity set by ACTIVE_LOW)
//   key_out     debounced key state, 1 = pressed (toggle latch with KEY_TOGGLE_EN)
//   key_press   one-cycle pulse on each debounced press
//   key_release one-cycle pulse on each debounced release
//   any_key     OR of key_out
//   key_code    index of lowest set bit of key_out
//   key_valid   equals any_key; qualifies key_code
// Optional build macro KEY_TOGGLE_EN: key_out inverts on every debounced press.
module key_debounce_scan #(
    parameter int NKEYS      = 9,
    parameter int TICK_DIV   = 100000,
    parameter int DEB_COUNT  = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NKEYS-1:0]         key_raw,
    output logic [NKEYS-1:0]         key_out,
    output logic [NKEYS-1:0]         key_press,
    output logic [NKEYS-1:0]         key_release,
    output logic                     any_key,
    output logic [$clog2(NKEYS)-1:0] key_code,
    output logic                     key_valid
);
    localparam int CW = $clog2(NKEYS);
    localparam int DW = $clog2(TICK_DIV);
    localparam int NW = $clog2(DEB_COUNT + 1);
    localparam logic [NKEYS-1:0] IDLE = {NKEYS{ACTIVE_LOW != 0}};

    logic [NKEYS-1:0] sync1_q, sync2_q, sample, stable_q, stable_d, rise, fall, out_d;
    logic [DW-1:0]    div_q, div_d;
    logic             tick;
    logic [NW-1:0]    cnt_q [NKEYS];
    logic [NW-1:0]    cnt_d [NKEYS];
    logic [CW-1:0]    code_d;

    always_comb begin
        // XOR with the idle level normalises the pins to active-high
        sample = sync2_q ^ IDLE;
        tick   = div_q == DW'(TICK_DIV - 1);
        div_d  = tick ? '0 : div_q + 1'b1;
        for (int i = 0; i < NKEYS; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i];
            if (tick) begin
                if (sample[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == NW'(DEB_COUNT - 1)) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
`ifdef KEY_TOGGLE_EN
        out_d = key_out ^ rise;
`else
        out_d = stable_d;
`endif
        // scan downwards so the lowest set index is the last one written
        code_d = '0;
        for (int i = NKEYS - 1; i >= 0; i--)
            if (out_d[i]) code_d = CW'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= IDLE;
            sync2_q     <= IDLE;
            div_q       <= '0;
            stable_q    <= '0;
            cnt_q       <= '{default: '0};
            key_out     <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_key     <= 1'b0;
            key_code    <= '0;
            key_valid   <= 1'b0;
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            key_out     <= out_d;
            key_press   <= rise;
            key_release <= fall;
            any_key     <= |out_d;
            key_code    <= code_d;
            key_valid   <= |out_d;
        end
    end
endmodule

// File: tb/tb_key_debounce_scan.sv
// tb_key_debounce_scan: directed self-checking bench for key_debounce_scan.
module tb_key_debounce_scan;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] key_raw = 9'h1FF;
    logic [8:0] key_out, key_press, key_release;
    logic       any_key, key_valid;
    logic [3:0] key_code;

    int n_chk = 0, n_fail = 0;
    int w_chg, w_np, w_nr, w_pc, w_rc, w_oth;

    key_debounce_scan #(.NKEYS(9), .TICK_DIV(4), .DEB_COUNT(3), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .key_out(key_out),
        .key_press(key_press), .key_release(key_release), .any_key(any_key),
        .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] raw;
        logic [8:0] out;
        logic [3:0] code;
        logic       valid;
    } vec_t;
    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic watch(input int cyc, input int k);
        logic       init;
        logic [8:0] msk;
        init  = key_out[k];
        msk   = 9'b1 << k;
        w_chg = -1; w_np = 0; w_nr = 0; w_pc = -1; w_rc = -1; w_oth = 0;
        for (int c = 1; c <= cyc; c++) begin
            step();
            if (w_chg < 0 && key_out[k] !== init) w_chg = c;
            if (key_press[k]) begin w_np++; w_pc = c; end
            if (key_release[k]) begin w_nr++; w_rc = c; end
            if (((key_press | key_release) & ~msk) != 9'h0) w_oth++;
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_keys"}, {key_out, key_press, key_release}, 27'h0);
        check({nm, "_enc"}, {any_key, key_valid, key_code}, 6'h0);
    endtask

    initial begin
        int bad, p2, p7, np2, np7, np;
        tbl[0] = '{9'h1FF, 9'h000, 4'd0, 1'b0};
        tbl[1] = '{9'h1F7, 9'h008, 4'd3, 1'b1};
        tbl[2] = '{9'h17B, 9'h084, 4'd2, 1'b1};
        tbl[3] = '{9'h17F, 9'h080, 4'd7, 1'b1};
        tbl[4] = '{9'h000, 9'h1FF, 4'd0, 1'b1};
        tbl[5] = '{9'h0FF, 9'h100, 4'd8, 1'b1};
        tbl[6] = '{9'h1FF, 9'h000, 4'd0, 1'b0};

        repeat (3) step();
        check_zero("reset_state");
        reset = 1'b0;
        repeat (10) step();
        check_zero("idle_after_reset");

`ifdef KEY_TOGGLE_EN
        key_raw[1] = 1'b0;
        watch(20, 1);
        check("tog_press1_pulses", w_np, 1);
        check("tog_press1_out", key_out, 9'h002);
        check("tog_press1_code", {key_valid, key_code}, 5'h11);
        key_raw[1] = 1'b1;
        watch(20, 1);
        check("tog_rel1_pulses", w_nr, 1);
        check("tog_rel1_unchanged", w_chg, -1);
        check("tog_rel1_out", key_out, 9'h002);
        np = w_nr;
        key_raw[1] = 1'b0;
        watch(20, 1);
        check("tog_press2_pulses", w_np, 1);
        check("tog_press2_lat", (w_chg >= 11 && w_chg <= 15) ? 1 : 0, 1);
        check("tog_press2_out", key_out, 9'h000);
        check("tog_press2_valid", any_key, 1'b0);
        key_raw[1] = 1'b1;
        watch(20, 1);
        check("tog_rel2_unchanged", w_chg, -1);
        check("tog_release_total", np + w_nr, 2);
        check("tog_other_pulses", w_oth, 0);
`else
        // clean press of key 3
        key_raw[3] = 1'b0;
        watch(20, 3);
        check("press3_lat", (w_chg >= 11 && w_chg <= 15) ? 1 : 0, 1);
        check("press3_pulses", w_np, 1);
        check("press3_same_cycle", w_pc, w_chg);
        check("press3_others", w_oth + w_nr, 0);
        check("press3_out", key_out, 9'h008);
        check("press3_code", {any_key, key_valid, key_code}, 6'h33);
        key_raw[3] = 1'b1;
        watch(20, 3);
        check("release3_pulses", w_nr, 1);
        check("release3_same_cycle", w_rc, w_chg);
        check_zero("release3_idle");

        // key 5 bounces every 3 cycles, then settles pressed
        np = 0;
        for (int i = 0; i < 20; i++) begin
            key_raw[5] = ~key_raw[5];
            repeat (3) begin
                step();
                if (key_press[5] || key_out[5]) np++;
            end
        end
        check("bounce_no_press", np, 0);
        key_raw[5] = 1'b0;
        watch(15, 5);
        check("bounce_settle_press", w_np, 1);
        check("bounce_settle_out", key_out, 9'h020);
        check("bounce_no_release", w_nr + w_oth, 0);
        key_raw[5] = 1'b1;
        repeat (20) step();

        // two-cycle glitch on key 0
        key_raw[0] = 1'b0;
        step();
        step();
        key_raw[0] = 1'b1;
        watch(100, 0);
        check("glitch_no_change", w_chg, -1);
        check("glitch_no_press", w_np + w_oth, 0);

        // keys 2 and 7 together
        key_raw = ~9'h084;
        p2 = -1; p7 = -1; np2 = 0; np7 = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (key_press[2]) begin p2 = c; np2++; end
            if (key_press[7]) begin p7 = c; np7++; end
        end
        check("multi_same_cycle", p7, p2);
        check("multi_counts", {np2[3:0], np7[3:0]}, 8'h11);
        check("multi_lat", (p2 >= 11 && p2 <= 15) ? 1 : 0, 1);
        check("multi_out", key_out, 9'h084);
        check("multi_code", key_code, 4'd2);
        key_raw[2] = 1'b1;
        watch(20, 2);
        check("multi_rel2", w_nr, 1);
        check("multi_rel2_others", w_oth, 0);
        check("multi_rel2_out", key_out, 9'h080);
        check("multi_rel2_code", {key_valid, key_code}, 5'h17);

        // table of steady-state patterns
        for (int i = 0; i < 7; i++) begin
            key_raw = tbl[i].raw;
            repeat (20) step();
            check($sformatf("tbl%0d_out", i), key_out, tbl[i].out);
            check($sformatf("tbl%0d_code", i), key_code, tbl[i].code);
            check($sformatf("tbl%0d_valid", i), {any_key, key_valid}, {2{tbl[i].valid}});
            check($sformatf("tbl%0d_pulses", i), {key_press, key_release}, 18'h0);
        end

        // reset while key 4 is held mid-count
        key_raw[4] = 1'b0;
        np = 0;
        repeat (6) begin
            step();
            if (key_press[4]) np++;
        end
        check("rst_pre_no_press", np, 0);
        reset = 1'b1;
        #1;
        bad = 0;
        if ({key_out, key_press, key_release, any_key, key_valid} != 29'h0 || key_code != 4'h0) bad++;
        repeat (3) begin
            step();
            if ({key_out, key_press, key_release, any_key, key_valid} != 29'h0 || key_code != 4'h0) bad++;
        end
        check("rst_outputs_zero", bad, 0);
        reset = 1'b0;
        watch(20, 4);
        check("rst_fresh_press", w_np, 1);
        check("rst_press_lat", (w_pc >= 11 && w_pc <= 15) ? 1 : 0, 1);
        check("rst_press_out", key_out, 9'h010);
        check("rst_press_code", key_code, 4'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
